// File: rtl/alu_logical_pkg.sv
// alu_logical_pkg: opcodes, FSM states and control-word layout for the alu_logical sequencer
package alu_logical_pkg;
   localparam logic [2:0] OP_PASSA = 3'd0;
   localparam logic [2:0] OP_AND   = 3'd1;
   localparam logic [2:0] OP_OR    = 3'd2;
   localparam logic [2:0] OP_NAND  = 3'd3;
   localparam logic [2:0] OP_NOR   = 3'd4;
   localparam logic [2:0] OP_XOR   = 3'd5;
   localparam logic [2:0] OP_XNOR  = 3'd6;
   localparam logic [2:0] OP_CLR   = 3'd7;
   typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE} state_e;
   localparam int CW_ANDL = 3;
   localparam int CW_ORL  = 2;
   localparam int CW_ZERO = 1;
   localparam int CW_INV  = 0;
   localparam logic [3:0] CW_NONE = 4'b0000;
   localparam logic [3:0] CW_AND  = 4'b1000;
   localparam logic [3:0] CW_OR   = 4'b0100;
   localparam logic [3:0] CW_CLR  = 4'b0010;
   localparam logic [3:0] CW_NOT  = 4'b0001;
   function automatic logic is_composite(input logic [2:0] op);
      return op == OP_XOR || op == OP_XNOR;
   endfunction
endpackage

// File: rtl/alu_logical.sv
// alu_logical: combinational bitwise logic unit driven by the sequencer
module alu_logical #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             andl,
   input  logic             orl,
   input  logic             zero,
   input  logic             inv,
   output logic [WIDTH-1:0] f
);
   logic [WIDTH-1:0] g;
   assign g = zero ? '0 : andl ? a & b : orl ? a | b : a;
   assign f = inv ? ~g : g;
endmodule

// File: rtl/alu_logical_seq_decode.sv
// alu_logical_seq_decode: (op, pass) to control word and operand-source select
module alu_logical_seq_decode
   import alu_logical_pkg::*;
(
   input  logic [2:0] op_i,
   input  state_e     state_i,
   output logic [3:0] cw_o,
   output logic       sel_t_o
);
   logic [3:0] single;
   logic       comp;
   always_comb begin
      comp   = is_composite(op_i);
      single = op_i == OP_AND  ? CW_AND :
               op_i == OP_OR   ? CW_OR :
               op_i == OP_NAND ? (CW_AND | CW_NOT) :
               op_i == OP_NOR  ? (CW_OR | CW_NOT) :
               op_i == OP_CLR  ? CW_CLR : CW_NONE;
      // XOR = (a|b) & ~(a&b); XNOR inverts the final pass
      cw_o    = state_i == P1 ? (comp ? CW_OR : single) :
                state_i == P2 ? (CW_AND | CW_NOT) :
                state_i == P3 ? (CW_AND | (op_i == OP_XNOR ? CW_NOT : CW_NONE)) : CW_NONE;
      sel_t_o = state_i == P3;
   end
endmodule

// File: rtl/alu_logical_seq.sv
// alu_logical_seq: handshake sequencer issuing single and multi-pass ops through alu_logical
module alu_logical_seq
   import alu_logical_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_andl,
   output logic             alu_orl,
   output logic             alu_zero,
   output logic             alu_inv,
   input  logic [WIDTH-1:0] alu_f,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             out_zf,
   output logic             out_nf
);
   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, t1_q, t1_d, t2_q, t2_d, f_q, f_d;
   logic             zf_q, zf_d, nf_q, nf_d;
   logic [3:0]       cw;
   logic             sel_t, active, last;

   alu_logical_seq_decode u_dec (
      .op_i   (op_q),
      .state_i(state_q),
      .cw_o   (cw),
      .sel_t_o(sel_t)
   );

   assign active    = state_q == P1 || state_q == P2 || state_q == P3;
   assign last      = state_q == P3 || (state_q == P1 && !is_composite(op_q));
   assign alu_a     = !active ? '0 : sel_t ? t1_q : a_q;
   assign alu_b     = !active ? '0 : sel_t ? t2_q : b_q;
   assign alu_andl  = cw[CW_ANDL];
   assign alu_orl   = cw[CW_ORL];
   assign alu_zero  = cw[CW_ZERO];
   assign alu_inv   = cw[CW_INV];
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign out_f     = f_q;
   assign out_zf    = zf_q;
   assign out_nf    = nf_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      f_d     = f_q;
      zf_d    = zf_q;
      nf_d    = nf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = P1;
            op_d    = in_op;
            a_d     = in_a;
            b_d     = in_b;
         end
         P1: begin
            state_d = is_composite(op_q) ? P2 : DONE;
            t1_d    = is_composite(op_q) ? alu_f : t1_q;
         end
         P2: begin
            state_d = P3;
            t2_d    = alu_f;
         end
         P3:   state_d = DONE;
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
      if (last) begin
         f_d  = alu_f;
         zf_d = ~|alu_f;
         nf_d = alu_f[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         t1_q    <= '0;
         t2_q    <= '0;
         f_q     <= '0;
         zf_q    <= 1'b0;
         nf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         f_q     <= f_d;
         zf_q    <= zf_d;
         nf_q    <= nf_d;
      end
   end
endmodule

// File: tb/tb_alu_logical_seq.sv
// tb_alu_logical_seq: directed scoreboard bench for alu_logical_seq driving alu_logical
module tb_alu_logical_seq;
   import alu_logical_pkg::*;

   typedef struct packed {
      logic [7:0] f;
      logic       zf;
      logic       nf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_ready, out_valid, out_ready, out_zf, out_nf;
   logic       alu_andl, alu_orl, alu_zero, alu_inv;
   logic [2:0] in_op;
   logic [7:0] in_a, in_b, alu_a, alu_b, alu_f, out_f;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [2:0] s_op[8] = '{OP_AND, OP_XOR, OP_OR, OP_XNOR, OP_NAND, OP_CLR, OP_NOR, OP_PASSA};
   int         idx, prev, cyc, got;
   logic       acc;

   always #5 clk = ~clk;

   alu_logical_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_andl(alu_andl),
      .alu_orl(alu_orl), .alu_zero(alu_zero), .alu_inv(alu_inv), .alu_f(alu_f),
      .out_valid(out_valid), .out_ready(out_ready), .out_f(out_f), .out_zf(out_zf),
      .out_nf(out_nf)
   );

   alu_logical #(.WIDTH(8)) u_alu (
      .a(alu_a), .b(alu_b), .andl(alu_andl), .orl(alu_orl), .zero(alu_zero),
      .inv(alu_inv), .f(alu_f)
   );

   function automatic exp_t exp_of(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      case (op)
         OP_PASSA: e.f = a;
         OP_AND:   e.f = a & b;
         OP_OR:    e.f = a | b;
         OP_NAND:  e.f = ~(a & b);
         OP_NOR:   e.f = ~(a | b);
         OP_XOR:   e.f = a ^ b;
         OP_XNOR:  e.f = ~(a ^ b);
         default:  e.f = 8'h00;
      endcase
      e.zf = e.f == 8'h00;
      e.nf = e.f[7];
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("send_ready", {31'd0, in_ready}, 1);
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      sb.push_back(exp_of(op, a, b));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic compare(input string tag);
      exp_t e = '0;
      check({tag, "_sb"}, {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) e = sb.pop_front();
      check({tag, "_f"}, {24'd0, out_f}, {24'd0, e.f});
      check({tag, "_zf"}, {31'd0, out_zf}, {31'd0, e.zf});
      check({tag, "_nf"}, {31'd0, out_nf}, {31'd0, e.nf});
   endtask

   task automatic recv(input string tag, input int n0, input int exp_lat, input int hold);
      int n = n0;
      logic [7:0] f0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
      f0 = out_f;
      compare(tag);
      repeat (hold) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, {31'd0, out_valid}, 1);
         check({tag, "_hold_f"}, {24'd0, out_f}, {24'd0, f0});
         check({tag, "_hold_ready"}, {31'd0, in_ready}, 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_drain"}, {31'd0, out_valid}, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", {31'd0, in_ready}, 1);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out", {22'd0, out_f, out_zf, out_nf}, 0);
      check("rst_alu", {12'd0, alu_a, alu_b, alu_andl, alu_orl, alu_zero, alu_inv}, 0);

      send(OP_AND,  8'hA8, 8'hD5); recv("and",  1, 2, 0);
      send(OP_OR,   8'hA8, 8'hD5); recv("or",   1, 2, 0);
      send(OP_NAND, 8'hA8, 8'hD5); recv("nand", 1, 2, 0);
      send(OP_NOR,  8'hA8, 8'hD5); recv("nor",  1, 2, 0);
      send(OP_XOR,  8'hA8, 8'hD5); recv("xor",  1, 4, 0);

      send(OP_XNOR, 8'hA8, 8'hD5);
      check("p1_ctrl", {28'd0, alu_andl, alu_orl, alu_zero, alu_inv}, 4'b0100);
      check("p1_ops", {16'd0, alu_a, alu_b}, 16'hA8D5);
      @(posedge clk); #1;
      check("p2_ctrl", {28'd0, alu_andl, alu_orl, alu_zero, alu_inv}, 4'b1001);
      check("p2_ops", {16'd0, alu_a, alu_b}, 16'hA8D5);
      @(posedge clk); #1;
      check("p3_ctrl", {28'd0, alu_andl, alu_orl, alu_zero, alu_inv}, 4'b1001);
      check("p3_ops", {16'd0, alu_a, alu_b}, 16'hFD7F);
      recv("xnor", 3, 4, 0);

      send(OP_AND,   8'h00, 8'hFF); recv("and0",  1, 2, 0);
      send(OP_XOR,   8'h00, 8'hFF); recv("xor0",  1, 4, 0);
      send(OP_CLR,   8'h00, 8'hFF); recv("clr0",  1, 2, 0);
      send(OP_PASSA, 8'h00, 8'hFF); recv("pass0", 1, 2, 0);

      send(OP_AND, 8'h5A, 8'h0F);
      in_op = OP_OR; in_a = 8'h12; in_b = 8'h21; in_valid = 1'b1;
      recv("bp", 1, 2, 5);
      check("bp_idle_ready", {31'd0, in_ready}, 1);
      sb.push_back(exp_of(OP_OR, 8'h12, 8'h21));
      @(posedge clk); #1;
      in_valid = 1'b0;
      recv("bp_next", 1, 2, 0);

      send(OP_XOR, 8'h3C, 8'hC3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      void'(sb.pop_back());
      check("mrst_ready", {31'd0, in_ready}, 1);
      check("mrst_valid", {31'd0, out_valid}, 0);
      check("mrst_alu", {12'd0, alu_a, alu_b, alu_andl, alu_orl, alu_zero, alu_inv}, 0);
      check("mrst_out", {22'd0, out_f, out_zf, out_nf}, 0);
      send(OP_AND, 8'hF0, 8'h3C); recv("post_rst", 1, 2, 0);

      idx = 0; prev = -1; cyc = 0; got = 0;
      out_ready = 1'b1;
      in_op = s_op[0]; in_a = 8'($urandom_range(255, 0)); in_b = 8'($urandom_range(255, 0));
      in_valid = 1'b1;
      while (got < 8 && cyc < 200) begin
         acc = in_valid && in_ready;
         if (acc) begin
            sb.push_back(exp_of(in_op, in_a, in_b));
            if (prev >= 0) check("stream_gap", cyc - prev, is_composite(s_op[idx-1]) ? 5 : 3);
            prev = cyc;
         end
         if (out_valid) begin
            compare("stream");
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 8) begin
               in_op = s_op[idx];
               in_a  = 8'($urandom_range(255, 0));
               in_b  = 8'($urandom_range(255, 0));
            end else in_valid = 1'b0;
         end
      end
      check("stream_count", got, 8);
      out_ready = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_logical_seq.md
Name: alu_logical_seq

Overview:
- Sequencing front-end for the 8-bit combinational logic unit `alu_logical`.
- Accepts an opcode plus two operands over a valid/ready handshake and drives the unit's operand and control inputs (a, b, andl, orl, zero, inv).
- Composite ops (XOR, XNOR) run as multi-pass sequences through the unit, with temporaries held in local registers.
- Returns a registered result with zero/negative flags over a second valid/ready handshake.

Parameters:
- WIDTH, 8, operand/result width; must match `alu_logical`.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_op  in  3  opcode: 000 PASSA, 001 AND, 010 OR, 011 NAND, 100 NOR, 101 XOR, 110 XNOR, 111 CLR
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- alu_a  out  WIDTH  to `alu_logical` a
- alu_b  out  WIDTH  to `alu_logical` b
- alu_andl  out  1  to `alu_logical` andl
- alu_orl  out  1  to `alu_logical` orl
- alu_zero  out  1  to `alu_logical` zero
- alu_inv  out  1  to `alu_logical` inv
- alu_f  in  WIDTH  from `alu_logical` f
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_f  out  WIDTH  result
- out_zf  out  1  out_f == 0
- out_nf  out  1  out_f[WIDTH-1]

Behaviour:
- Unit contract (combinational, same cycle):
  - g = zero ? 0 : andl ? a&b : orl ? a|b : a
  - f = inv ? ~g : g
- Reset: state IDLE. in_ready=1. out_valid=0. out_f/zf/nf=0. All alu_* outputs and temporaries t1/t2 = 0.
- States: IDLE, P1, P2, P3, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch op/a/b, go to P1.
  - in_ready=0 in every other state.
- Control words per pass (alu_* are combinational from state + latched op; 0 in IDLE/DONE):
  - PASSA: P1 = {a, b, 0000}
  - AND: P1 = andl
  - OR: P1 = orl
  - NAND: P1 = andl+inv
  - NOR: P1 = orl+inv
  - CLR: P1 = zero
  - XOR/XNOR:
    - P1 = orl on a,b; t1 <= alu_f
    - P2 = andl+inv on a,b; t2 <= alu_f
    - P3 = andl on t1,t2 (XNOR adds inv)
- Result capture:
  - Single-pass ops: P1 -> DONE; alu_f captured at end of P1.
  - XOR/XNOR: P1 -> P2 -> P3 -> DONE; alu_f captured at end of P3.
- Latency from accept edge to out_valid=1: single-pass 2 cycles; XOR/XNOR 4 cycles.
- DONE:
  - out_valid=1; out_f/zf/nf are stable until the handshake completes.
  - On out_ready, go to IDLE and out_valid=0 next cycle.
  - Min issue interval: 3 cycles single-pass, 5 cycles composite.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE; the latched operands are not disturbed.
- Width rules: all ops are bitwise on WIDTH bits; no carry, no sign extension.
- Reset asserted mid-sequence (any state): next cycle is IDLE with every output at its reset value. Any in-flight result is discarded.
- Illegal encodings: none; all 8 opcodes are defined.

Decomposition:
- Package alu_logical_pkg holds:
  - Opcode localparams (OP_PASSA..OP_CLR).
  - State encoding.
  - Control-word bit positions {andl, orl, zero, inv}.
- Sub-module alu_logical_seq_decode: combinational (op, pass) -> 4-bit control word plus operand-source select (inputs vs t1/t2).
- `alu_logical` is instantiated beside this block at the next level up; the bench instantiates both.

Test Plan:
- a=0xA8, b=0xD5, ops AND/OR/NAND/NOR -> out_f 0x80/0xFD/0x7F/0x02, out_valid exactly 2 cycles after accept, zf=0.
- a=0xA8, b=0xD5, XOR then XNOR -> 0x7D then 0x82, 4-cycle latency each, alu_* passes match the sequence above; XNOR nf=1.
- a=0x00, b=0xFF: AND -> 0x00 zf=1; XOR -> 0xFF nf=1; CLR -> 0x00 zf=1; PASSA -> 0x00 zf=1.
- Backpressure: hold out_ready=0 for 5 cycles with a new in_valid pending -> out_f stable, in_ready=0; result drains on out_ready, new op accepted the following IDLE cycle.
- Reset asserted during P2 of an XOR -> next cycle IDLE, out_valid=0, alu_* = 0; a following AND 0xF0/0x3C completes with 0x30.
- Back-to-back stream of 8 ops with out_ready tied 1 -> results in issue order, intervals of 3/5 cycles.
